// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter and its grant logic.
package mem_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant: on a tie the port that did not win last time
// gets the grant. Purely combinational so other shared resources can reuse it.
module rr_arb2 import mem_pkg::*; (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // Pick at most one requester, favouring the port opposite last_grant
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || (last_grant == PORT_LSU))) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single memory port.
// Port 0 is instruction fetch (read only), port 1 is load/store.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to add the access timeout and
// the sticky err output.
module mem_arbiter import mem_pkg::*; #(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic              err,
`endif
  output logic              busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_port_q, gnt_port_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              p0_done_q, p0_done_d;
  logic              p1_done_q, p1_done_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              busy_q, busy_d;
  logic [1:0]        gnt;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  rr_arb2 u_rr_arb2 (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Next-state logic: grant in IDLE, hold strobes in ACCESS, one-cycle DONE
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_port_d   = gnt_port_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    p0_done_d    = 1'b0;
    p1_done_d    = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          gnt_port_d   = gnt[1];
          last_grant_d = gnt[1];
          if (gnt[1]) begin
            mem_addr_d  = p1_addr;
            mem_wdata_d = p1_wdata;
            mem_read_d  = !p1_we;
            mem_write_d = p1_we;
          end else begin
            mem_addr_d  = p0_addr;
            mem_wdata_d = '0;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
          end
          state_d = ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (gnt_port_q == PORT_LSU) begin
            p1_done_d = 1'b1;
            if (mem_read_q) p1_rdata_d = mem_rdata;
          end else begin
            p0_done_d = 1'b1;
            if (mem_read_q) p0_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_d       = 1'b1;
          if (gnt_port_q == PORT_LSU) begin
            p1_done_d  = 1'b1;
            p1_rdata_d = '0;
          end else begin
            p0_done_d  = 1'b1;
            p0_rdata_d = '0;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset drops any in-flight access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_LSU;
      gnt_port_q   <= PORT_FETCH;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      p0_done_q    <= 1'b0;
      p1_done_q    <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      busy_q       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_port_q   <= gnt_port_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      p0_done_q    <= p0_done_d;
      p1_done_q    <= p1_done_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      busy_q       <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign p0_done   = p0_done_q;
  assign p1_done   = p1_done_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign busy      = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run, all compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif
  localparam int MaxRandWait = (TO - 1 < 6) ? TO - 1 : 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_done, p1_done;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;
`ifdef MEM_ARB_TIMEOUT_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef MEM_ARB_TIMEOUT_EN
    .err(err),
`endif
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: where the arbiter is in the current transaction
  typedef enum {M_FREE, M_ACC, M_DONE} phase_t;
  phase_t        phase = M_FREE;
  int            lastPort = 1;
  int            curPort = 0;
  bit            curWrite = 0;
  logic [AW-1:0] curAddr = '0;
  logic [DW-1:0] curWdata = '0;
  logic [DW-1:0] expRdata [2] = '{default: '0};
  int            waitCnt = 0;
  bit            expErr = 0;
  bit            mDone [2] = '{default: 1'b0};
  bit            holdOne [2] = '{default: 1'b0};
  int            readyDelay = 0;

  // Values present on the inputs at the edge being modelled
  bit            sRst, sReq0, sReq1, sWe, sReady;
  logic [AW-1:0] sA0, sA1;
  logic [DW-1:0] sWd, sRdata;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the spec rules to one sampled edge, then compare every output
  task automatic modelEdge();
    bit strobe;
    mDone[0] = 1'b0;
    mDone[1] = 1'b0;
    if (!sRst) begin
      phase = M_FREE;
      lastPort = 1;
      expRdata[0] = '0;
      expRdata[1] = '0;
      expErr = 1'b0;
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
    end else begin
      case (phase)
        M_FREE: begin
          if (sReq0 || sReq1) begin
            if (sReq0 && sReq1) curPort = 1 - lastPort;
            else curPort = sReq1 ? 1 : 0;
            lastPort = curPort;
            curWrite = (curPort == 1) && sWe;
            curAddr = (curPort == 1) ? sA1 : sA0;
            curWdata = sWd;
            waitCnt = 0;
            phase = M_ACC;
          end
        end
        M_ACC: begin
          if (sReady) begin
            if (!curWrite) expRdata[curPort] = sRdata;
            mDone[curPort] = 1'b1;
            phase = M_DONE;
          end else begin
            waitCnt++;
`ifdef MEM_ARB_TIMEOUT_EN
            if (waitCnt == TO) begin
              expRdata[curPort] = '0;
              mDone[curPort] = 1'b1;
              expErr = 1'b1;
              phase = M_DONE;
            end
`endif
          end
        end
        default: phase = M_FREE;
      endcase
    end
    strobe = (phase == M_ACC);
    checkOutput("mem_read", mem_read, strobe && !curWrite);
    checkOutput("mem_write", mem_write, strobe && curWrite);
    checkOutput("strobe_excl", mem_read & mem_write, 0);
    if (strobe) checkOutput("mem_addr", mem_addr, curAddr);
    if (strobe && curWrite) checkOutput("mem_wdata", mem_wdata, curWdata);
    checkOutput("busy", busy, phase != M_FREE);
    checkOutput("p0_done", p0_done, mDone[0]);
    checkOutput("p1_done", p1_done, mDone[1]);
    checkOutput("p0_rdata", p0_rdata, expRdata[0]);
    checkOutput("p1_rdata", p1_rdata, expRdata[1]);
`ifdef MEM_ARB_TIMEOUT_EN
    checkOutput("err", err, expErr);
`endif
  endtask

  task automatic stepCycle();
    sRst = rst_n; sReq0 = p0_req; sReq1 = p1_req; sWe = p1_we;
    sA0 = p0_addr; sA1 = p1_addr; sWd = p1_wdata;
    sReady = mem_ready; sRdata = mem_rdata;
    @(posedge clk);
    #1;
    modelEdge();
  endtask

  task automatic scramblePort(input int i);
    if (i == 0) begin
      p0_addr = $urandom();
    end else begin
      p1_addr = $urandom();
      p1_wdata = $urandom();
      p1_we = $urandom_range(0, 1);
    end
  endtask

  task automatic setReq(input int i, input bit v);
    if (i == 0) p0_req = v;
    else p1_req = v;
  endtask

  // Random requester: hold until done, keep through the done cycle, then decide
  task automatic drivePort(input int i);
    bit req;
    req = (i == 0) ? p0_req : p1_req;
    if (mDone[i]) begin
      holdOne[i] = 1'b1;
    end else if (holdOne[i]) begin
      holdOne[i] = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        scramblePort(i);
        setReq(i, 1'b1);
      end else begin
        setReq(i, 1'b0);
      end
    end else if (req) begin
      if (phase == M_ACC && curPort == i) scramblePort(i);
    end else begin
      scramblePort(i);
      if ($urandom_range(0, 2) == 0) setReq(i, 1'b1);
    end
  endtask

  // Drive memory response and (optionally) random requesters for the next edge
  task automatic applyStimulus(input bit randomReq);
    if (phase == M_ACC) begin
      if (readyDelay >= 0) mem_ready = (waitCnt == readyDelay);
      else mem_ready = (waitCnt >= MaxRandWait) || ($urandom_range(0, 2) == 0);
    end else begin
      mem_ready = ($urandom_range(0, 3) == 0);
    end
    mem_rdata = $urandom();
    if (randomReq) begin
      rst_n = ($urandom_range(0, 149) != 0);
      drivePort(0);
      drivePort(1);
    end
  endtask

  task automatic runCycle(input bit randomReq);
    stepCycle();
    applyStimulus(randomReq);
  endtask

  task automatic waitDone(input int port, input int budget);
    int n;
    n = 0;
    while (!mDone[port] && n < budget) begin
      runCycle(1'b0);
      n++;
    end
    checkOutput("wait_done_in_budget", mDone[port], 1);
  endtask

  task automatic goIdle();
    int n;
    rst_n = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    readyDelay = 0;
    n = 0;
    while (phase != M_FREE && n < 40) begin
      runCycle(1'b0);
      n++;
    end
    runCycle(1'b0);
    checkOutput("go_idle", phase == M_FREE, 1);
  endtask

  initial begin
    int order[$];
    int strobeCycles;
    int n;

    // Reset state
    repeat (3) runCycle(1'b0);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    runCycle(1'b0);

    // Single fetch with immediate ready
    $display("[TB] single fetch");
    readyDelay = 0;
    p0_req = 1'b1;
    p0_addr = 32'h10;
    runCycle(1'b0);
    mem_rdata = 32'hDEADBEEF;
    checkOutput("fetch_read", mem_read, 1);
    checkOutput("fetch_addr", mem_addr, 32'h10);
    runCycle(1'b0);
    checkOutput("fetch_done", p0_done, 1);
    checkOutput("fetch_rdata", p0_rdata, 32'hDEADBEEF);
    runCycle(1'b0);
    p0_req = 1'b0;
    runCycle(1'b0);

    // LSU write
    $display("[TB] lsu write");
    readyDelay = 2;
    p1_req = 1'b1;
    p1_we = 1'b1;
    p1_addr = 32'h20;
    p1_wdata = 32'h12345678;
    waitDone(1, 20);
    checkOutput("write_rdata_kept", p1_rdata, 0);
    runCycle(1'b0);
    p1_req = 1'b0;
    p1_we = 1'b0;
    runCycle(1'b0);

    // Continuous contention, four transactions
    $display("[TB] contention");
    readyDelay = 0;
    p0_req = 1'b1;
    p0_addr = 32'h100;
    p1_req = 1'b1;
    p1_addr = 32'h200;
    n = 0;
    while (order.size() < 4 && n < 40) begin
      runCycle(1'b0);
      if (p0_done) order.push_back(0);
      if (p1_done) order.push_back(1);
      n++;
    end
    runCycle(1'b0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    runCycle(1'b0);
    checkOutput("contention_count", order.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) checkOutput("contention_order", order[k], k % 2);
    end

    // Stretched ready
    $display("[TB] stretched ready");
    readyDelay = 5;
    p0_req = 1'b1;
    p0_addr = 32'h44;
    waitDone(0, 20);
    runCycle(1'b0);
    p0_req = 1'b0;
    runCycle(1'b0);

    // Randomized traffic
    $display("[TB] random traffic");
    readyDelay = -1;
    holdOne[0] = 1'b0;
    holdOne[1] = 1'b0;
    repeat (1500) runCycle(1'b1);
    goIdle();

    // Reset in the middle of an access
    $display("[TB] reset mid-access");
    readyDelay = 3;
    p1_req = 1'b1;
    p1_we = 1'b0;
    p1_addr = 32'h300;
    runCycle(1'b0);
    runCycle(1'b0);
    rst_n = 1'b0;
    p0_req = 1'b1;
    p0_addr = 32'h400;
    runCycle(1'b0);
    checkOutput("midrst_read", mem_read, 0);
    checkOutput("midrst_done", p0_done | p1_done, 0);
    checkOutput("midrst_busy", busy, 0);
    rst_n = 1'b1;
    runCycle(1'b0);
    checkOutput("midrst_p0_first", mem_addr, 32'h400);
    waitDone(0, 20);
    goIdle();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog timeout with mem_ready never arriving
    $display("[TB] timeout");
    readyDelay = 1000;
    p1_req = 1'b1;
    p1_we = 1'b0;
    p1_addr = 32'h500;
    strobeCycles = 0;
    n = 0;
    while (!mDone[1] && n < 20) begin
      runCycle(1'b0);
      mem_ready = 1'b0;
      if (mem_read) strobeCycles++;
      n++;
    end
    checkOutput("timeout_done", p1_done, 1);
    checkOutput("timeout_strobe_cycles", strobeCycles, TO);
    checkOutput("timeout_rdata", p1_rdata, 0);
    checkOutput("timeout_err", err, 1);
    runCycle(1'b0);
    p1_req = 1'b0;
    runCycle(1'b0);
    checkOutput("timeout_idle", busy, 0);
`else
    strobeCycles = 0;
`endif

    repeat (3) runCycle(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
